// File: rtl/vid_to_axis_if.sv
// AXI4-Stream video channel between vid_to_axis and its consumer.
interface vid_to_axis_if #(
  parameter int DATA_W = 36
);
  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic              m_tuser;
  logic              m_tlast;

  modport master (output m_tdata, m_tvalid, m_tuser, m_tlast, input m_tready);
  modport slave  (input m_tdata, m_tvalid, m_tuser, m_tlast, output m_tready);
endinterface

// File: rtl/vid_to_axis.sv
// Parallel video (de/vsync/pixel) to AXI4-Stream video bridge with a frame-granular
// overflow recovery FIFO, line-length checking and sticky status.
module vid_to_axis #(
  parameter int DATA_W   = 36,
  parameter int FIFO_AW  = 11,
  parameter int H_ACTIVE = 1920
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               vid_de,
  input  logic               vid_vsync,
  input  logic [DATA_W-1:0]  vid_data,
  vid_to_axis_if.master      m,
  input  logic               stat_clr,
  output logic               ovf,
  output logic               len_err,
  output logic [15:0]        frame_cnt,
  output logic [FIFO_AW:0]   fifo_level
);
  localparam int DEPTH = 2**FIFO_AW;
  localparam int EW    = DATA_W + 2;

  typedef enum logic [1:0] {WAIT_VS, RUN, DROP} state_t;
  state_t state, state_nx;

  logic              vs_q, vs_rise, sof_pend;
  logic              de_q;
  logic [11:0]       len_cnt;
  logic              len_fail;

  logic              stg_v, stg_sof;
  logic [DATA_W-1:0] stg_data;

  logic [EW-1:0]      mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   level, mem_cnt;
  logic               full, wr_req, wr_eol, wr_ok, wr_drop, load, pop, hs;

  logic [DATA_W-1:0] out_data;
  logic              out_valid, out_user, out_last;

  assign vs_rise = vid_vsync & ~vs_q;
  assign full    = (level == (FIFO_AW+1)'(DEPTH));
  assign hs      = out_valid & m.m_tready;
  // level also counts the entry held in the output register
  assign mem_cnt = level - {{FIFO_AW{1'b0}}, out_valid};
  assign pop     = (mem_cnt != '0) & (~out_valid | m.m_tready);
  assign wr_ok   = wr_req & ~full;
  assign wr_drop = wr_req & full;

  always_comb begin
    state_nx = state;
    wr_req   = 1'b0;
    wr_eol   = 1'b0;
    load     = 1'b0;
    unique case (state)
      WAIT_VS: if (vs_rise) state_nx = RUN;
      RUN: begin
        if (vid_de) begin
          wr_req = stg_v;
          load   = 1'b1;
        end else if (stg_v) begin
          wr_req = 1'b1;
          wr_eol = 1'b1;
        end
        if (wr_req && full) begin
          state_nx = DROP;
          load     = 1'b0;
        end
      end
      DROP:    if (vs_rise) state_nx = RUN;
      default: state_nx = WAIT_VS;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= WAIT_VS;
      vs_q     <= 1'b0;
      sof_pend <= 1'b0;
      de_q     <= 1'b0;
    end else begin
      state <= state_nx;
      vs_q  <= vid_vsync;
      de_q  <= vid_de;
      // a pixel loaded together with vs_rise still uses the old sof_pend
      if (vs_rise)   sof_pend <= 1'b1;
      else if (load) sof_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stg_v    <= 1'b0;
      stg_sof  <= 1'b0;
      stg_data <= '0;
    end else if (wr_drop) begin
      stg_v <= 1'b0;
    end else if (load) begin
      stg_v    <= 1'b1;
      stg_sof  <= sof_pend;
      stg_data <= vid_data;
    end else if (wr_ok) begin
      stg_v <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= {stg_sof, wr_eol, stg_data};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_ok, hs})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_user  <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (pop) begin
      out_valid                      <= 1'b1;
      {out_user, out_last, out_data} <= mem[rd_ptr];
    end else if (hs) begin
      out_valid <= 1'b0;
    end
  end

  assign m.m_tdata  = out_data;
  assign m.m_tvalid = out_valid;
  assign m.m_tuser  = out_user;
  assign m.m_tlast  = out_last;

  assign len_fail = ~vid_de & de_q & (state == RUN) & (len_cnt != 12'(H_ACTIVE));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len_cnt <= '0;
    end else if (vid_de && !de_q) begin
      len_cnt <= 12'd1;
    end else if (vid_de && (len_cnt != '1)) begin
      len_cnt <= len_cnt + 12'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf       <= 1'b0;
      len_err   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (wr_drop)       ovf <= 1'b1;
      else if (stat_clr) ovf <= 1'b0;
      if (len_fail)      len_err <= 1'b1;
      else if (stat_clr) len_err <= 1'b0;
      if (wr_ok && stg_sof) frame_cnt <= stat_clr ? 16'd1 : frame_cnt + 16'd1;
      else if (stat_clr)    frame_cnt <= '0;
    end
  end

  assign fifo_level = level;
endmodule

// File: tb/tb_vid_to_axis.sv
// Randomized bench for vid_to_axis: a frame-level model predicts the AXIS beat stream.
module tb_vid_to_axis;
  localparam int DATA_W  = 36;
  localparam int FIFO_AW = 4;
  localparam int DEPTH   = 16;
  localparam int H_ACT   = 12;

  typedef struct packed {
    logic              sof;
    logic              eol;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              vid_de = 1'b0;
  logic              vid_vsync = 1'b0;
  logic              stat_clr = 1'b0;
  logic [DATA_W-1:0] vid_data = '0;
  logic              ovf, len_err;
  logic [15:0]       frame_cnt;
  logic [FIFO_AW:0]  fifo_level;

  vid_to_axis_if #(.DATA_W(DATA_W)) axis ();

  vid_to_axis #(.DATA_W(DATA_W), .FIFO_AW(FIFO_AW), .H_ACTIVE(H_ACT)) dut (
    .clk(clk), .rstn(rstn), .vid_de(vid_de), .vid_vsync(vid_vsync), .vid_data(vid_data),
    .m(axis), .stat_clr(stat_clr), .ovf(ovf), .len_err(len_err),
    .frame_cnt(frame_cnt), .fifo_level(fifo_level)
  );

  int          total = 0;
  int          bad = 0;
  int          rdy_mode = 1;
  int unsigned cyc = 0;
  int          stall_viol = 0;
  beat_t       exp_q[$];
  beat_t       got_q[$];
  int unsigned stamp_q[$];
  int unsigned sof_cyc_q[$];
  logic        prev_stall = 1'b0;
  beat_t       prev_b = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Beat monitor and AXIS stability observer, sampled at the falling edge.
  always @(negedge clk) begin
    if (!rstn) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (!axis.m_tvalid || ({axis.m_tuser, axis.m_tlast, axis.m_tdata} != prev_b)))
        stall_viol <= stall_viol + 1;
      if (axis.m_tvalid && axis.m_tready) begin
        got_q.push_back({axis.m_tuser, axis.m_tlast, axis.m_tdata});
        stamp_q.push_back(cyc);
      end
      prev_stall <= axis.m_tvalid && !axis.m_tready;
      prev_b     <= {axis.m_tuser, axis.m_tlast, axis.m_tdata};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       axis.m_tready = 1'b0;
      1:       axis.m_tready = 1'b1;
      default: axis.m_tready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic blank(input int n);
    vid_de = 1'b0;
    repeat (n) tick();
  endtask

  task automatic pulse_clr();
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
  endtask

  task automatic vsync_pulse();
    vid_vsync = 1'b1;
    tick();
    tick();
    vid_vsync = 1'b0;
    blank(4);
  endtask

  task automatic drive_line(input int len, input bit rec, input bit sof);
    for (int p = 0; p < len; p++) begin
      vid_de   = 1'b1;
      vid_data = {4'($urandom), 32'($urandom)};
      if (rec) exp_q.push_back({sof && (p == 0), p == len - 1, vid_data});
      if (rec && sof && p == 0) sof_cyc_q.push_back(cyc);
      tick();
    end
    vid_de = 1'b0;
  endtask

  // Model: every active pixel of a frame becomes a beat; first of frame has sof, last of run has eol.
  task automatic drive_frame(input int lines, input int hb, input int short_line);
    vsync_pulse();
    for (int l = 0; l < lines; l++) begin
      drive_line((l == short_line) ? H_ACT - 1 : H_ACT, 1'b1, l == 0);
      blank(hb);
    end
  endtask

  task automatic wait_drain(input int gb, input int budget, output bit timeout);
    int n = 0;
    while ((axis.m_tvalid || fifo_level != 0 || (got_q.size() - gb) < exp_q.size()) && n < budget) begin
      tick();
      n++;
    end
    timeout = (n >= budget);
    repeat (3) tick();
  endtask

  function automatic int diff_idx(input int gb);
    for (int i = 0; i < exp_q.size() && (gb + i) < got_q.size(); i++)
      if (got_q[gb + i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    rstn = 1'b0;
    rdy_mode = 1;
    repeat (3) tick();
    total++; if ({axis.m_tvalid, axis.m_tuser, axis.m_tlast} !== 3'b000) begin
      bad++; $display("FAIL reset_ctl got=%b exp=000", {axis.m_tvalid, axis.m_tuser, axis.m_tlast}); end
    total++; if (axis.m_tdata !== '0) begin
      bad++; $display("FAIL reset_tdata got=%h exp=0", axis.m_tdata); end
    total++; if ({ovf, len_err} !== 2'b00) begin
      bad++; $display("FAIL reset_status got=%b exp=00", {ovf, len_err}); end
    total++; if (frame_cnt !== 16'd0) begin
      bad++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); end
    total++; if (fifo_level !== '0) begin
      bad++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_mid_frame_start();
    int gb, k;
    bit to;
    exp_q.delete();
    rdy_mode = 1;
    rstn = 1'b0;
    tick();
    for (int p = 0; p < H_ACT; p++) begin
      vid_de   = 1'b1;
      vid_data = {4'($urandom), 32'($urandom)};
      if (p == 5) rstn = 1'b1;
      tick();
    end
    blank(6);
    gb = got_q.size();
    drive_line(H_ACT, 1'b0, 1'b0);
    blank(10);
    total++; if (got_q.size() != gb) begin
      bad++; $display("FAIL midstart_no_beats got=%0d exp=0", got_q.size() - gb); end
    drive_frame(3, 8, -1);
    wait_drain(gb, 500, to);
    total++; if (to) begin bad++; $display("FAIL midstart_drain timeout got=1 exp=0"); end
    total++; if (got_q.size() - gb != exp_q.size()) begin
      bad++; $display("FAIL midstart_count got=%0d exp=%0d", got_q.size() - gb, exp_q.size()); end
    k = diff_idx(gb);
    total++; if (k != -1) begin
      bad++; $display("FAIL midstart_beat idx=%0d got=%h exp=%h", k, got_q[gb + k], exp_q[k]); end
    total++; if (got_q.size() > gb && got_q[gb].sof !== 1'b1) begin
      bad++; $display("FAIL midstart_first_tuser got=%b exp=1", got_q[gb].sof); end
  endtask

  task automatic test_normal();
    int gb, k, gaps;
    bit to;
    rdy_mode = 1;
    pulse_clr();
    exp_q.delete();
    sof_cyc_q.delete();
    gb = got_q.size();
    drive_frame(4, 8, -1);
    drive_frame(4, 8, -1);
    wait_drain(gb, 800, to);
    total++; if (to) begin bad++; $display("FAIL normal_drain timeout got=1 exp=0"); end
    total++; if (got_q.size() - gb != exp_q.size()) begin
      bad++; $display("FAIL normal_count got=%0d exp=%0d", got_q.size() - gb, exp_q.size()); end
    k = diff_idx(gb);
    total++; if (k != -1) begin
      bad++; $display("FAIL normal_beat idx=%0d got=%h exp=%h", k, got_q[gb + k], exp_q[k]); end
    total++; if (frame_cnt !== 16'd2) begin
      bad++; $display("FAIL normal_frame_cnt got=%0d exp=2", frame_cnt); end
    total++; if ({ovf, len_err} !== 2'b00) begin
      bad++; $display("FAIL normal_status got=%b exp=00", {ovf, len_err}); end
    total++; if (got_q.size() > gb && stamp_q[gb] !== sof_cyc_q[0] + 3) begin
      bad++; $display("FAIL normal_latency got=%0d exp=%0d", stamp_q[gb], sof_cyc_q[0] + 3); end
    gaps = 0;
    for (int i = gb + 1; i < got_q.size(); i++)
      if (!got_q[i-1].eol && stamp_q[i] != stamp_q[i-1] + 1) gaps++;
    total++; if (gaps !== 0) begin
      bad++; $display("FAIL normal_throughput gaps got=%0d exp=0", gaps); end
  endtask

  task automatic test_back_pressure();
    int gb, k, sv;
    bit to;
    rdy_mode = 1;
    pulse_clr();
    exp_q.delete();
    gb = got_q.size();
    sv = stall_viol;
    rdy_mode = 2;
    drive_frame(3, 40, -1);
    drive_frame(3, 40, -1);
    wait_drain(gb, 2000, to);
    rdy_mode = 1;
    tick();
    total++; if (to) begin bad++; $display("FAIL bp_drain timeout got=1 exp=0"); end
    total++; if (got_q.size() - gb != exp_q.size()) begin
      bad++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size() - gb, exp_q.size()); end
    k = diff_idx(gb);
    total++; if (k != -1) begin
      bad++; $display("FAIL bp_beat idx=%0d got=%h exp=%h", k, got_q[gb + k], exp_q[k]); end
    total++; if (stall_viol - sv !== 0) begin
      bad++; $display("FAIL bp_stable_while_stalled got=%0d exp=0", stall_viol - sv); end
    total++; if ({ovf, frame_cnt} !== {1'b0, 16'd2}) begin
      bad++; $display("FAIL bp_status got ovf=%b cnt=%0d exp ovf=0 cnt=2", ovf, frame_cnt); end
  endtask

  task automatic test_overflow();
    int gb, k;
    bit to;
    rdy_mode = 1;
    pulse_clr();
    exp_q.delete();
    gb = got_q.size();
    rdy_mode = 0;
    vsync_pulse();
    for (int p = 0; p < 24; p++) begin
      vid_de   = 1'b1;
      vid_data = {4'($urandom), 32'($urandom)};
      if (p < DEPTH) exp_q.push_back({p == 0, 1'b0, vid_data});
      tick();
      if (p == 16) begin
        total++; if ({ovf, fifo_level} !== {1'b0, 5'(DEPTH)}) begin
          bad++; $display("FAIL ovf_before got ovf=%b lvl=%0d exp ovf=0 lvl=%0d", ovf, fifo_level, DEPTH); end
      end
      if (p == 17) begin
        total++; if (ovf !== 1'b1) begin
          bad++; $display("FAIL ovf_set got=%b exp=1", ovf); end
      end
    end
    blank(4);
    total++; if (fifo_level !== 5'(DEPTH)) begin
      bad++; $display("FAIL ovf_level got=%0d exp=%0d", fifo_level, DEPTH); end
    drive_line(H_ACT, 1'b0, 1'b0);
    blank(8);
    rdy_mode = 1;
    blank(30);
    total++; if (got_q.size() - gb != DEPTH) begin
      bad++; $display("FAIL ovf_drain_count got=%0d exp=%0d", got_q.size() - gb, DEPTH); end
    drive_frame(2, 8, -1);
    wait_drain(gb, 500, to);
    total++; if (to) begin bad++; $display("FAIL ovf_drain timeout got=1 exp=0"); end
    total++; if (got_q.size() - gb != exp_q.size()) begin
      bad++; $display("FAIL ovf_count got=%0d exp=%0d", got_q.size() - gb, exp_q.size()); end
    k = diff_idx(gb);
    total++; if (k != -1) begin
      bad++; $display("FAIL ovf_beat idx=%0d got=%h exp=%h", k, got_q[gb + k], exp_q[k]); end
  endtask

  task automatic test_len_err();
    int gb, k;
    bit to;
    rdy_mode = 1;
    pulse_clr();
    exp_q.delete();
    gb = got_q.size();
    drive_frame(3, 8, 1);
    wait_drain(gb, 500, to);
    total++; if (to) begin bad++; $display("FAIL len_drain timeout got=1 exp=0"); end
    k = diff_idx(gb);
    total++; if (k != -1 || got_q.size() - gb != exp_q.size()) begin
      bad++; $display("FAIL len_beats idx=%0d got_n=%0d exp_n=%0d", k, got_q.size() - gb, exp_q.size()); end
    total++; if ({len_err, ovf, frame_cnt} !== {1'b1, 1'b0, 16'd1}) begin
      bad++; $display("FAIL len_err_set got le=%b ovf=%b cnt=%0d exp le=1 ovf=0 cnt=1", len_err, ovf, frame_cnt); end
    pulse_clr();
    total++; if ({len_err, ovf, frame_cnt} !== {1'b0, 1'b0, 16'd0}) begin
      bad++; $display("FAIL len_stat_clr got le=%b ovf=%b cnt=%0d exp all 0", len_err, ovf, frame_cnt); end
  endtask

  task automatic test_async_reset();
    int gb, k;
    bit to;
    rdy_mode = 1;
    pulse_clr();
    exp_q.delete();
    rdy_mode = 0;
    vsync_pulse();
    drive_line(8, 1'b0, 1'b0);
    blank(2);
    total++; if (fifo_level !== 5'd8) begin
      bad++; $display("FAIL arst_pre_level got=%0d exp=8", fifo_level); end
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    total++; if ({axis.m_tvalid, axis.m_tuser, axis.m_tlast, ovf, len_err} !== 5'b0) begin
      bad++; $display("FAIL arst_ctl got=%b exp=00000",
                      {axis.m_tvalid, axis.m_tuser, axis.m_tlast, ovf, len_err}); end
    total++; if ({axis.m_tdata, frame_cnt, fifo_level} !== '0) begin
      bad++; $display("FAIL arst_data got tdata=%h cnt=%0d lvl=%0d exp 0", axis.m_tdata, frame_cnt, fifo_level); end
    tick();
    rstn = 1'b1;
    rdy_mode = 1;
    gb = got_q.size();
    blank(4);
    drive_line(H_ACT, 1'b0, 1'b0);
    blank(10);
    total++; if (got_q.size() != gb) begin
      bad++; $display("FAIL arst_no_beats got=%0d exp=0", got_q.size() - gb); end
    drive_frame(2, 8, -1);
    wait_drain(gb, 500, to);
    total++; if (to) begin bad++; $display("FAIL arst_drain timeout got=1 exp=0"); end
    k = diff_idx(gb);
    total++; if (k != -1 || got_q.size() - gb != exp_q.size()) begin
      bad++; $display("FAIL arst_beats idx=%0d got_n=%0d exp_n=%0d", k, got_q.size() - gb, exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_mid_frame_start();
    test_normal();
    test_back_pressure();
    test_overflow();
    test_len_err();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
